// File: rtl/uart_pkg.sv
// uart_pkg: receiver state type, oversampling ratio and tick divisor helper
package uart_pkg;
    localparam int OVERSAMPLE = 16;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
    function automatic int calc_div(input int clk_freq, input int baud_rate);
        return (clk_freq / (baud_rate * OVERSAMPLE) < 1) ? 1 : clk_freq / (baud_rate * OVERSAMPLE);
    endfunction
endpackage

// File: rtl/uart_os_tick.sv
// uart_os_tick: one-clk oversample tick every DIV clocks, counter held at 0 while en=0
module uart_os_tick #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic os_tick
);
    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    logic [W-1:0] cnt;
    assign os_tick = en && (cnt == W'(DIV - 1));
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt <= '0;
        else if (!en || os_tick) cnt <= '0;
        else cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/uart_rx_os.sv
// uart_rx_os: 16x oversampled 8N1 UART receiver with valid/ready output, framing and overrun pulses
import uart_pkg::*;
module uart_rx_os #(
    parameter int clk_freq  = 1000000,
    parameter int baud_rate = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rxdata,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun
);
    localparam int DIV = calc_div(clk_freq, baud_rate);
    rx_state_t state, state_n;
    logic       rx_m, rx_s, rx_p, os_tick, deliver, deliver_n, frame_err_n;
    logic [3:0] sample_cnt, sample_cnt_n;
    logic [2:0] bit_cnt, bit_cnt_n;
    logic [7:0] sh, sh_n;
    uart_os_tick #(.DIV(DIV)) u_tick (
        .clk(clk), .rst(rst), .en(state != IDLE), .os_tick(os_tick)
    );
    always_comb begin
        state_n      = state;
        sample_cnt_n = sample_cnt;
        bit_cnt_n    = bit_cnt;
        sh_n         = sh;
        frame_err_n  = 1'b0;
        deliver_n    = 1'b0;
        case (state)
            IDLE: if (rx_p && !rx_s) begin
                state_n      = START;
                sample_cnt_n = '0;
            end
            START: if (os_tick) begin
                sample_cnt_n = sample_cnt + 4'd1;
                if (sample_cnt == 4'(OVERSAMPLE / 2 - 1)) begin
                    sample_cnt_n = '0;
                    bit_cnt_n    = '0;
                    state_n      = rx_s ? IDLE : DATA;
                end
            end
            DATA: if (os_tick) begin
                sample_cnt_n = sample_cnt + 4'd1;
                if (sample_cnt == 4'(OVERSAMPLE - 1)) begin
                    sh_n      = {rx_s, sh[7:1]};
                    bit_cnt_n = bit_cnt + 3'd1;
                    state_n   = (bit_cnt == 3'd7) ? STOP : DATA;
                end
            end
            STOP: if (os_tick) begin
                sample_cnt_n = sample_cnt + 4'd1;
                if (sample_cnt == 4'(OVERSAMPLE - 1)) begin
                    state_n     = IDLE;
                    frame_err_n = !rx_s;
                    deliver_n   = rx_s;
                end
            end
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            sample_cnt <= '0;
            bit_cnt    <= '0;
            sh         <= '0;
            rx_m       <= 1'b1;
            rx_s       <= 1'b1;
            rx_p       <= 1'b1;
            deliver    <= 1'b0;
        end else begin
            state      <= state_n;
            sample_cnt <= sample_cnt_n;
            bit_cnt    <= bit_cnt_n;
            sh         <= sh_n;
            rx_m       <= rx;
            rx_s       <= rx_m;
            rx_p       <= rx_s;
            deliver    <= deliver_n;
        end
    end
    // a delivery wins over a same-edge consume; a blocked delivery keeps the old byte
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rxdata    <= 8'h00;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= frame_err_n;
            overrun   <= deliver && rx_valid && !rx_ready;
            if (deliver && (!rx_valid || rx_ready)) begin
                rxdata   <= sh;
                rx_valid <= 1'b1;
            end else if (rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_os.sv
// tb_uart_rx_os: scoreboard bench driving 8N1 frames and checking bytes, framing errors and overruns
module tb_uart_rx_os;
    localparam int BIT = 160;
    localparam int EV_FE = 1;
    localparam int EV_OV = 2;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx = 1'b1;
    logic       rx_ready = 1'b1;
    logic [7:0] rxdata;
    logic       rx_valid, frame_err, overrun;
    int n_checks = 0;
    int n_fail = 0;
    logic [7:0] byte_q[$];
    int         err_q[$];
    logic       held = 1'b0;
    logic       prev_valid = 1'b0;
    logic [7:0] prev_data = 8'h00;

    uart_rx_os #(.clk_freq(1600000), .baud_rate(10000)) dut (
        .clk(clk), .rst(rst), .rx(rx), .rxdata(rxdata), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .frame_err(frame_err), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // reference: what an 8N1 receiver with a one-deep output holding register must report
    task automatic expect_frame(input logic [7:0] d, input logic stop);
        if (!stop) err_q.push_back(EV_FE);
        else if (held && !rx_ready) err_q.push_back(EV_OV);
        else begin
            byte_q.push_back(d);
            held = !rx_ready;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        expect_frame(d, stop);
        rx = 1'b0;
        wait_clk(BIT);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            wait_clk(BIT);
        end
        rx = stop;
        wait_clk(BIT);
        rx = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rxdata"}, rxdata, 8'h00);
        check({tag, "_valid"}, rx_valid, 0);
        check({tag, "_frame_err"}, frame_err, 0);
        check({tag, "_overrun"}, overrun, 0);
    endtask

    always @(negedge clk) begin
        if (!rst) prev_valid <= 1'b0;
        else begin
            if (prev_valid && rx_valid) check("rxdata_stable", rxdata, prev_data);
            if (rx_valid && rx_ready) begin
                if (byte_q.size() == 0) check("unexpected_byte", rxdata, -1);
                else check("byte", rxdata, byte_q.pop_front());
            end
            if (frame_err) begin
                if (err_q.size() == 0) check("unexpected_frame_err", 1, 0);
                else check("frame_err_event", EV_FE, err_q.pop_front());
            end
            if (overrun) begin
                if (err_q.size() == 0) check("unexpected_overrun", 1, 0);
                else check("overrun_event", EV_OV, err_q.pop_front());
            end
            prev_valid <= rx_valid && !rx_ready;
            prev_data  <= rxdata;
        end
    end

    initial begin
        int lat, n;
        logic [7:0] d;
        logic stop;
        wait_clk(3);
        check_reset_outputs("reset");
        rst = 1'b1;
        wait_clk(50);

        fork
            send_frame(8'hA5, 1'b1);
            begin
                lat = 0;
                while (!rx_valid && lat < 3000) begin
                    @(posedge clk);
                    lat++;
                    #1;
                end
                check("a5_latency_window", (lat >= 1518 && lat <= 1530), 1);
                check("a5_data", rxdata, 8'hA5);
                wait_clk(1);
                check("a5_valid_one_cycle", rx_valid, 0);
            end
        join
        wait_clk(200);

        rx = 1'b0;
        wait_clk(30);
        rx = 1'b1;
        wait_clk(2 * BIT);
        send_frame(8'h3C, 1'b1);
        wait_clk(100);

        send_frame(8'h3C, 1'b0);
        rx = 1'b0;
        wait_clk(20 * BIT);
        check("held_low_valid", rx_valid, 0);
        rx = 1'b1;
        wait_clk(2 * BIT);
        send_frame(8'h55, 1'b1);
        wait_clk(100);

        rx_ready = 1'b0;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        wait_clk(100);
        check("ovr_valid_held", rx_valid, 1);
        check("ovr_data_held", rxdata, 8'h11);
        rx_ready = 1'b1;
        held = 1'b0;
        wait_clk(2);
        check("ovr_valid_cleared", rx_valid, 0);
        check("ovr_data_after_clear", rxdata, 8'h11);
        wait_clk(100);

        rx = 1'b0;
        wait_clk(BIT);
        for (int i = 0; i < 4; i++) begin
            rx = i[0];
            wait_clk(BIT);
        end
        rx = 1'b0;
        wait_clk(BIT / 2);
        #2 rst = 1'b0;
        #1 check_reset_outputs("async_reset");
        rx = 1'b1;
        wait_clk(5);
        rst = 1'b1;
        held = 1'b0;
        wait_clk(3 * BIT);
        send_frame(8'hF0, 1'b1);
        wait_clk(100);

        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        wait_clk(100);

        for (int k = 0; k < 20; k++) begin
            d = 8'($urandom);
            stop = ($urandom_range(0, 5) != 0);
            send_frame(d, stop);
            wait_clk(stop ? $urandom_range(0, 200) : $urandom_range(20, 200));
        end

        n = 0;
        while ((byte_q.size() != 0 || err_q.size() != 0) && n < 5000) begin
            wait_clk(1);
            n++;
        end
        check("leftover_bytes", byte_q.size(), 0);
        check("leftover_events", err_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_rx_os.md
UART_RX_OS -- requirements
Module: uart_rx_os

Interface
REQ-001 Parameter clk_freq, default 1000000, system clock frequency in Hz.
REQ-002 Parameter baud_rate, default 9600, line bit rate in bit/s.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 rx  input  1  asynchronous serial line; idles high.
REQ-006 rxdata  output  8  received byte; stable while rx_valid=1.
REQ-007 rx_valid  output  1  rxdata holds an unconsumed byte.
REQ-008 rx_ready  input  1  consumer accepts rxdata when rx_valid=1 and rx_ready=1 on a clk edge.
REQ-009 frame_err  output  1  one-cycle pulse when the stop bit is sampled low.
REQ-010 overrun  output  1  one-cycle pulse when a completed byte is dropped.

Function
REQ-011 Frame format: 1 start bit (0), 8 data bits LSB-first, 1 stop bit (1), no parity.
REQ-012 rx passes through a 2-flop synchronizer (rx_s), reset value 1; a third register rx_p holds the previous rx_s for edge detection.
REQ-013 Oversample tick: divisor DIV = clk_freq/(baud_rate*16), integer-truncated, minimum 1; os_tick is a one-clk pulse every DIV clocks.
REQ-014 The tick counter is held at 0 in IDLE and starts counting on the clock after start detection.
REQ-015 States: IDLE, START, DATA, STOP.
REQ-016 IDLE: falling edge (rx_p=1, rx_s=0) -> START, sample_cnt=0; a constant-low line does not trigger.
REQ-017 START: sample_cnt increments per os_tick; at the tick where sample_cnt=7, rx_s=0 -> DATA (sample_cnt=0, bit_cnt=0), rx_s=1 -> IDLE (false start, no outputs).
REQ-018 DATA: at the tick where sample_cnt=15, shift rx_s into the MSB of an 8-bit shift register ({rx_s, sh[7:1]}), increment bit_cnt, wrap sample_cnt to 0; after the 8th sample -> STOP.
REQ-019 STOP: at the tick where sample_cnt=15, sample rx_s; 1 -> deliver the byte (REQ-020); 0 -> frame_err=1 for one cycle, byte discarded; both cases -> IDLE.
REQ-020 Delivery: on the clock following the stop sample, if rx_valid=0, or rx_valid=1 and rx_ready=1 on that same edge, load rxdata and set rx_valid=1; otherwise keep the old rxdata, keep rx_valid=1, and pulse overrun for one cycle.
REQ-021 rx_valid clears on an edge with rx_ready=1 and no simultaneous delivery; rx_ready with rx_valid=0 has no effect.
REQ-022 Sampling points fall at mid-bit; sampling uses rx_s only, never raw rx.

Reset
REQ-023 While rst=0: state=IDLE, counters=0, shift register=0, rx_s=rx_p=1, rxdata=8'h00, rx_valid=0, frame_err=0, overrun=0, all applied immediately regardless of clk.
REQ-024 A reset mid-frame abandons the frame with no output pulses; after release the block waits for a new falling edge.

Structure
REQ-025 Package uart_pkg holds the rx state typedef (2-bit enum) and the constant OVERSAMPLE=16.
REQ-026 One sub-module, uart_os_tick, generates os_tick from DIV with an enable/clear input; everything else is in uart_rx_os.

Verification (clk_freq=1600000, baud_rate=10000: DIV=10, 160 clk per bit)
REQ-027 Test 0xA5 with rx_ready=1: rxdata=8'hA5 and rx_valid high for one cycle, frame_err=0, about 9.5 bit times plus 3 clk after the start edge.
REQ-028 Test a 30-clk low glitch on an idle line: no rx_valid, frame_err or overrun; a following 0x3C is received correctly.
REQ-029 Test 0x3C with the stop bit forced 0, then rx held low for 2 frame times: exactly one frame_err pulse and no rx_valid; after rx returns high, 0x55 is received correctly.
REQ-030 Test rx_ready=0 while sending 0x11 then 0x22: rxdata=8'h11 is held and overrun pulses once at the second stop sample; rx_ready=1 clears rx_valid with rxdata still 8'h11.
REQ-031 Test rst=0 asserted during bit 4 of a frame: outputs reach reset values asynchronously; after release, 0xF0 is received correctly with no spurious pulses.
REQ-032 Test back-to-back 0x00 and 0xFF with one stop bit and rx_ready=1: both bytes delivered in order, no frame_err or overrun.
